// File: rtl/gray_arbiter_if.sv
// Request/grant and status bundle shared between gray_arbiter and its requesters.
// The master side drives requests, step counts and Clr; the slave side is the arbiter.
interface gray_arbiter_if;
    logic [1:0] Req;
    logic [3:0] Steps0;
    logic [3:0] Steps1;
    logic       Clr;
    logic [1:0] Gnt;
    logic       Busy;
    logic       Done;
    logic [2:0] Output;
    logic       Overflow;

    modport master (
        output Req, Steps0, Steps1, Clr,
        input  Gnt, Busy, Done, Output, Overflow
    );

    modport slave (
        input  Req, Steps0, Steps1, Clr,
        output Gnt, Busy, Done, Output, Overflow
    );
endinterface

// File: rtl/gray_arbiter.sv
// Two-requester round-robin arbiter; the owner runs a job of N steps on a shared
// 3-bit Gray counter, with a sticky overflow flag on each 100->000 wrap.
module gray_arbiter (
    input  logic           Clk,
    input  logic           Reset,
    gray_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [3:0] remaining_q, remaining_d;
    logic [2:0] count_q, count_d;
    logic       overflow_q, overflow_d;

    logic       ownerReq;
    logic       advance;
    logic       wrap;
    logic [3:0] stepsSel;

    function automatic logic [2:0] grayNext(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        b    = b + 3'd1;
        return b ^ (b >> 1);
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            remaining_q <= 4'd0;
            count_q     <= 3'b000;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Losing the owner's request in GRANT or RUN aborts the job and still counts as its turn.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        remaining_d = remaining_q;
        advance     = 1'b0;
        ownerReq    = bus.Req[owner_q];
        stepsSel    = owner_q ? bus.Steps1 : bus.Steps0;

        unique case (state_q)
            IDLE: begin
                if (bus.Req != 2'b00) begin
                    owner_d = (bus.Req == 2'b11) ? ~last_q : bus.Req[1];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!ownerReq) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end else begin
                    remaining_d = (stepsSel > 4'd8) ? 4'd8 : stepsSel;
                    state_d     = (stepsSel == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!ownerReq) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end else begin
                    advance     = 1'b1;
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A wrap on the same edge as Clr keeps the flag set.
    always_comb begin
        count_d    = advance ? grayNext(count_q) : count_q;
        wrap       = advance && (count_q == 3'b100);
        overflow_d = wrap ? 1'b1 : (bus.Clr ? 1'b0 : overflow_q);
    end

    assign bus.Gnt      = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign bus.Busy     = (state_q != IDLE);
    assign bus.Done     = (state_q == DONE);
    assign bus.Output   = count_q;
    assign bus.Overflow = overflow_q;

endmodule

// File: tb/tb_gray_arbiter.sv
// Randomized and directed bench for gray_arbiter, checked every cycle against a
// job-level reference model that tracks the counter as a position in the Gray sequence.
module tb_gray_arbiter;

    logic clk;
    logic reset;

    gray_arbiter_if bus ();

    gray_arbiter dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 granted, 2 stepping, 3 finishing
    int grayTab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int mPhase = 0;
    int mOwner = 0;
    int mLast  = 1;
    int mLeft  = 0;
    int mPos   = 0;
    int mOvf   = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep();
        int req;
        int steps;
        bit wrapped;
        req     = int'(bus.Req);
        wrapped = 1'b0;
        if (reset) begin
            mPhase = 0; mOwner = 0; mLast = 1; mLeft = 0; mPos = 0; mOvf = 0;
            return;
        end
        case (mPhase)
            0: if (req != 0) begin
                if (req == 3) mOwner = 1 - mLast;
                else          mOwner = (req == 1) ? 0 : 1;
                mPhase = 1;
            end
            1: if (((req >> mOwner) & 1) == 0) begin
                mLast = mOwner; mPhase = 0;
            end else begin
                steps  = (mOwner == 1) ? int'(bus.Steps1) : int'(bus.Steps0);
                mLeft  = (steps > 8) ? 8 : steps;
                mPhase = (mLeft == 0) ? 3 : 2;
            end
            2: if (((req >> mOwner) & 1) == 0) begin
                mLast = mOwner; mPhase = 0;
            end else begin
                mPos = (mPos + 1) % 8;
                if (mPos == 0) wrapped = 1'b1;
                mLeft--;
                if (mLeft == 0) mPhase = 3;
            end
            default: begin
                mLast = mOwner; mPhase = 0;
            end
        endcase
        if (wrapped)      mOvf = 1;
        else if (bus.Clr) mOvf = 0;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [3:0] s0, input logic [3:0] s1,
                                 input logic clr, input logic rst, input int cycles);
        bus.Req    = req;
        bus.Steps0 = s0;
        bus.Steps1 = s1;
        bus.Clr    = clr;
        reset      = rst;
        for (int c = 0; c < cycles; c++) begin
            modelStep();
            @(posedge clk);
            #1;
            checkOutput("Gnt",      int'(bus.Gnt),      (mPhase == 0) ? 0 : (1 << mOwner));
            checkOutput("Busy",     int'(bus.Busy),     (mPhase != 0) ? 1 : 0);
            checkOutput("Done",     int'(bus.Done),     (mPhase == 3) ? 1 : 0);
            checkOutput("Output",   int'(bus.Output),   grayTab[mPos]);
            checkOutput("Overflow", int'(bus.Overflow), mOvf);
        end
    endtask

    initial begin
        logic [1:0] rReq;
        logic [3:0] rS0;
        logic [3:0] rS1;
        logic       rClr;
        logic       rRst;

        // Three-step job from reset, then idle
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0, 1'b1, 2);
        applyStimulus(2'b01, 4'd3, 4'd0, 1'b0, 1'b0, 6);
        checkOutput("Output after 3 steps", int'(bus.Output), 2);
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2);

        // Full eight-step lap from 000 wraps and sets Overflow; Clr alone clears it
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0, 1'b1, 1);
        applyStimulus(2'b10, 4'd0, 4'd8, 1'b0, 1'b0, 11);
        checkOutput("Overflow after lap", int'(bus.Overflow), 1);
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2);
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1);
        checkOutput("Overflow after Clr", int'(bus.Overflow), 0);

        // Continuous tie alternates owners, starting with requester 0
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0, 1'b1, 1);
        applyStimulus(2'b11, 4'd1, 4'd1, 1'b0, 1'b0, 16);

        // Zero-step job, then saturation of 15 to 8 steps
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2);
        applyStimulus(2'b01, 4'd0, 4'd0, 1'b0, 1'b0, 4);
        applyStimulus(2'b10, 4'd0, 4'd15, 1'b0, 1'b0, 14);

        // Abort after two steps, then reset in the middle of a job
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0, 1'b1, 1);
        applyStimulus(2'b01, 4'd5, 4'd0, 1'b0, 1'b0, 4);
        applyStimulus(2'b00, 4'd5, 4'd0, 1'b0, 1'b0, 3);
        checkOutput("Output after abort", int'(bus.Output), 3);
        applyStimulus(2'b01, 4'd5, 4'd0, 1'b0, 1'b0, 4);
        applyStimulus(2'b01, 4'd5, 4'd0, 1'b0, 1'b1, 1);
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1);

        // Clr held through a lap: the wrap edge wins, the following edge clears
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0, 1'b1, 1);
        applyStimulus(2'b10, 4'd0, 4'd8, 1'b1, 1'b0, 10);
        checkOutput("Overflow on wrap with Clr", int'(bus.Overflow), 1);
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1);
        checkOutput("Overflow Clr after wrap", int'(bus.Overflow), 0);

        // Random traffic with sticky requests so jobs usually complete
        rReq = 2'b00;
        rS0  = 4'd0;
        rS1  = 4'd0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) rReq = 2'($urandom_range(0, 3));
            rS0  = 4'($urandom_range(0, 15));
            rS1  = 4'($urandom_range(0, 15));
            rClr = ($urandom_range(0, 15) == 0);
            rRst = ($urandom_range(0, 299) == 0);
            applyStimulus(rReq, rS0, rS1, rClr, rRst, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_arbiter.md
GRAY_ARBITER -- requirements
Module: gray_arbiter

Interface
REQ-001 SHALL have port Clk  input  1  rising-edge clock.
REQ-002 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-003 SHALL have port Req  input  2  per-requester request; bit i belongs to requester i.
REQ-004 SHALL have port Steps0  input  4  step count for requester 0, sampled at grant.
REQ-005 SHALL have port Steps1  input  4  step count for requester 1, sampled at grant.
REQ-006 SHALL have port Clr  input  1  clears sticky Overflow.
REQ-007 SHALL have port Gnt  output  2  one-hot grant; 00 when no owner.
REQ-008 SHALL have port Busy  output  1  high in GRANT, RUN and DONE states.
REQ-009 SHALL have port Done  output  1  one-cycle pulse on job completion.
REQ-010 SHALL have port Output  output  3  current Gray counter value.
REQ-011 SHALL have port Overflow  output  1  sticky wrap flag.

Function
REQ-012 SHALL contain one 3-bit Gray counter with sequence 000,001,011,010,110,111,101,100,000; it advances one code per RUN cycle and holds otherwise.
REQ-013 SHALL implement FSM states IDLE, GRANT, RUN, DONE.
REQ-014 IDLE: if Req!=00, SHALL select a winner, assert the winner's Gnt bit and go to GRANT next cycle; else stay in IDLE with Gnt=00.
REQ-015 Arbitration SHALL be round-robin: 1-bit pointer Last holds the last served requester; when both request, the requester != Last wins; with a single request, that requester wins.
REQ-016 GRANT: SHALL latch the winner's Steps into a 4-bit Remaining register; values above 8 SHALL saturate to 8; if the latched value is 0, go to DONE, else go to RUN.
REQ-017 RUN: each cycle SHALL advance the counter and decrement Remaining; when Remaining==1 at the edge, go to DONE; N steps SHALL take exactly N RUN cycles.
REQ-018 DONE: SHALL assert Done for exactly one cycle with Gnt held, set Last to the owner, and return to IDLE.
REQ-019 Grant-to-done latency SHALL be 1 (GRANT) + N (RUN) cycles, then the Done cycle; IDLE re-arbitrates on the cycle after DONE.
REQ-020 If the owner's Req bit is low in GRANT or RUN, SHALL abort: go to IDLE next cycle with no Done pulse and no further counter advance, and set Last to the aborted owner.
REQ-021 Requests from the non-owner during GRANT, RUN or DONE SHALL be ignored until IDLE; Steps inputs are ignored outside GRANT.
REQ-022 Overflow SHALL set on the RUN edge where the counter goes 100->000 and hold until Clr or Reset; when a wrap and Clr coincide, set SHALL win.
REQ-023 Counter value SHALL persist across jobs; it is never reset by grant, abort or Done.
REQ-024 Gnt SHALL be one-hot or zero at all times.

Reset
REQ-025 On Reset SHALL force state IDLE, Output=000, Overflow=0, Gnt=00, Busy=0, Done=0, Remaining=0, Last=1 (requester 0 wins the first tie).
REQ-026 Reset SHALL take priority over all other inputs, including mid-RUN; counting resumes only via a new grant.

Verification
REQ-027 After reset, Req=01 and Steps0=3 held -> Gnt=01 from the next cycle; Output 001, 011, 010 on successive RUN cycles; Done pulse one cycle after Output=010; then Gnt=00.
REQ-028 From Output=000, Req=10 and Steps1=8 -> 8 RUN cycles ending at Output=000; Overflow=1 on the wrap edge and still 1 after Done.
REQ-029 Req=11 held continuously with Steps0=Steps1=1 -> grants alternate 01, 10, 01, ... starting with 01 after reset.
REQ-030 Steps0=0 -> GRANT, then DONE: Done pulses with no Output change; Steps1=15 -> exactly 8 advances.
REQ-031 Owner drops Req after 2 RUN cycles of a 5-step job -> counter stops at the 2nd code, no Done, back to IDLE; Reset asserted mid-RUN -> all outputs at reset values on the next cycle.
REQ-032 Clr asserted on the same edge as a 100->000 wrap -> Overflow=1; Clr alone on the next cycle -> Overflow=0.
